fsm_ctx_scheduler: RTL and testbench

- Time-multiplexes one shared combinational two-bit FSM evaluator (inputs a, b, ps; outputs ns, y) across NCH independent channels.
- Holds a 2-bit state context per channel and arbitrates evaluation requests round-robin.
- Drives the evaluator with the granted channel's context and inputs, writes ns back, and reports y per evaluation.
- Sits between requesting channel logic and the single evaluator instance.

---
 rtl/fsm_ctx_scheduler.sv | 142 ++++++++++++++
 tb/tb_fsm_ctx_scheduler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_ctx_scheduler.sv
// Round-robin context scheduler that shares one external two-bit FSM evaluator
// across NCH channels, keeping each channel's state and writing ns back.
module fsm_ctx_scheduler #(
  parameter int NCH = 4,
  parameter int IDW = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   req,
  input  logic [NCH-1:0]   a_in,
  input  logic [NCH-1:0]   b_in,
  input  logic [NCH-1:0]   ctx_clr,
  output logic [NCH-1:0]   ack,
  output logic [1:0]       ev_ps,
  output logic             ev_a,
  output logic             ev_b,
  input  logic [1:0]       ev_ns,
  input  logic             ev_y,
  output logic             res_valid,
  output logic [IDW-1:0]   res_ch,
  output logic [1:0]       res_ns,
  output logic             res_y,
  output logic [2*NCH-1:0] ctx_state
);

  logic [1:0]     ctx_r [NCH];
  logic [IDW-1:0] rr_ptr_r;
  logic           e_valid_r;
  logic [IDW-1:0] e_id_r;
  logic [NCH-1:0] ack_r;
  logic [1:0]     ev_ps_r;
  logic           ev_a_r;
  logic           ev_b_r;
  logic           res_valid_r;
  logic [IDW-1:0] res_ch_r;
  logic [1:0]     res_ns_r;
  logic           res_y_r;

  logic [NCH-1:0] elig_s;
  logic           grant_vld_s;
  logic [IDW-1:0] grant_id_s;
  logic [IDW-1:0] ptr_next_s;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NCH) begin
      s = s - NCH;
    end else begin
      s = s;
    end
    return IDW'(s);
  endfunction

  // Round-robin pick of the first eligible channel at or after the pointer
  always_comb begin
    logic hit;
    elig_s      = req & ~ack_r & ~ctx_clr;
    grant_vld_s = 1'b0;
    grant_id_s  = {IDW{1'b0}};
    hit         = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      hit         = !grant_vld_s && elig_s[wrap_add(rr_ptr_r, k)];
      grant_id_s  = hit ? wrap_add(rr_ptr_r, k) : grant_id_s;
      grant_vld_s = grant_vld_s | hit;
    end
    ptr_next_s = wrap_add(grant_id_s, 1);
  end

  // Stage A registers; evaluator drive is captured here so it is stable for stage E
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r  <= {IDW{1'b0}};
      e_valid_r <= 1'b0;
      e_id_r    <= {IDW{1'b0}};
      ack_r     <= {NCH{1'b0}};
      ev_ps_r   <= 2'b00;
      ev_a_r    <= 1'b0;
      ev_b_r    <= 1'b0;
    end else if (grant_vld_s) begin
      rr_ptr_r  <= ptr_next_s;
      e_valid_r <= 1'b1;
      e_id_r    <= grant_id_s;
      ack_r     <= {{(NCH-1){1'b0}}, 1'b1} << grant_id_s;
      ev_ps_r   <= ctx_r[grant_id_s];
      ev_a_r    <= a_in[grant_id_s];
      ev_b_r    <= b_in[grant_id_s];
    end else begin
      e_valid_r <= 1'b0;
      ack_r     <= {NCH{1'b0}};
    end
  end

  // Context writeback (clear wins) and result reporting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        ctx_r[i] <= 2'b00;
      end
      res_valid_r <= 1'b0;
      res_ch_r    <= {IDW{1'b0}};
      res_ns_r    <= 2'b00;
      res_y_r     <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (ctx_clr[i]) begin
          ctx_r[i] <= 2'b00;
        end else if (e_valid_r && (e_id_r == IDW'(i))) begin
          ctx_r[i] <= ev_ns;
        end else begin
          ctx_r[i] <= ctx_r[i];
        end
      end
      if (e_valid_r) begin
        res_valid_r <= 1'b1;
        res_ch_r    <= e_id_r;
        res_ns_r    <= ev_ns;
        res_y_r     <= ev_y;
      end else begin
        res_valid_r <= 1'b0;
      end
    end
  end

  // Flatten contexts onto the status bus
  always_comb begin
    ctx_state = {(2*NCH){1'b0}};
    for (int i = 0; i < NCH; i++) begin
      ctx_state[2*i +: 2] = ctx_r[i];
    end
  end

  assign ack       = ack_r;
  assign ev_ps     = ev_ps_r;
  assign ev_a      = ev_a_r;
  assign ev_b      = ev_b_r;
  assign res_valid = res_valid_r;
  assign res_ch    = res_ch_r;
  assign res_ns    = res_ns_r;
  assign res_y     = res_y_r;

endmodule

// File: tb/tb_fsm_ctx_scheduler.sv
// Bench for fsm_ctx_scheduler: directed scenarios plus random traffic compared
// against a cycle-level reference model of channels, pointer and results.
module tb_fsm_ctx_scheduler;
  localparam int NCH = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] req = '0;
  logic [NCH-1:0] a_in = '0;
  logic [NCH-1:0] b_in = '0;
  logic [NCH-1:0] ctx_clr = '0;
  logic [NCH-1:0] ack;
  logic [1:0]     ev_ps;
  logic           ev_a;
  logic           ev_b;
  logic [1:0]     ev_ns;
  logic           ev_y;
  logic           res_valid;
  logic [IDW-1:0] res_ch;
  logic [1:0]     res_ns;
  logic           res_y;
  logic [2*NCH-1:0] ctx_state;

  int checks = 0;
  int errors = 0;

  fsm_ctx_scheduler #(.NCH(NCH), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
    .ctx_clr(ctx_clr), .ack(ack), .ev_ps(ev_ps), .ev_a(ev_a), .ev_b(ev_b),
    .ev_ns(ev_ns), .ev_y(ev_y), .res_valid(res_valid), .res_ch(res_ch),
    .res_ns(res_ns), .res_y(res_y), .ctx_state(ctx_state)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] spec_ns(input logic [1:0] ps, input logic a, input logic b);
    case (ps)
      2'b00:   return a ? 2'b01 : 2'b00;
      2'b01:   return b ? 2'b10 : 2'b00;
      default: return 2'b00;
    endcase
  endfunction

  // The shared evaluator instance the scheduler drives
  always_comb begin
    ev_ns = spec_ns(ev_ps, ev_a, ev_b);
    ev_y  = (ev_ps == 2'b10);
  end

  for (genvar g = 0; g < NCH; g++) begin : g_proto
    assert property (@(posedge clk) disable iff (!rst_n) $fell(req[g]) |-> ack[g])
      else $error("FAIL req_drop ch%0d dropped before ack", g);
  end

  // Reference model state and expected outputs
  logic [1:0]     m_ctx [NCH];
  int             m_ptr;
  bit             m_v;
  int             m_id;
  bit             m_a, m_b;
  logic [NCH-1:0] x_ack;
  bit             x_rv;
  int             x_rch, x_rns, x_ry;
  int             x_eps, x_ea, x_eb;
  logic [NCH-1:0] prev_ack;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < NCH; i++) m_ctx[i] = 2'b00;
    m_ptr = 0; m_v = 0; m_id = 0; m_a = 0; m_b = 0;
    x_ack = '0; x_rv = 0; x_rch = 0; x_rns = 0; x_ry = 0;
    x_eps = 0; x_ea = 0; x_eb = 0;
  endtask

  // Advance the model across one clock edge using the inputs currently driven
  task automatic model_edge();
    logic [NCH-1:0] elig;
    logic [1:0] ns;
    bit found;
    int c;
    elig = req & ~x_ack & ~ctx_clr;
    if (m_v) begin
      ns = spec_ns(m_ctx[m_id], m_a, m_b);
      x_rv = 1; x_rch = m_id; x_rns = int'(ns); x_ry = (m_ctx[m_id] == 2'b10) ? 1 : 0;
      m_ctx[m_id] = ns;
    end else begin
      x_rv = 0;
    end
    for (int i = 0; i < NCH; i++) if (ctx_clr[i]) m_ctx[i] = 2'b00;
    found = 0; c = 0;
    for (int k = 0; k < NCH; k++) begin
      if (!found && elig[(m_ptr + k) % NCH]) begin
        found = 1; c = (m_ptr + k) % NCH;
      end
    end
    if (found) begin
      m_v = 1; m_id = c; m_a = a_in[c]; m_b = b_in[c];
      m_ptr = (c + 1) % NCH;
      x_ack = '0; x_ack[c] = 1'b1;
      x_eps = int'(m_ctx[c]); x_ea = m_a ? 1 : 0; x_eb = m_b ? 1 : 0;
    end else begin
      m_v = 0; x_ack = '0;
    end
  endtask

  task automatic check_all();
    logic [2*NCH-1:0] xs;
    for (int i = 0; i < NCH; i++) xs[2*i +: 2] = m_ctx[i];
    chk("ack", 32'(ack), 32'(x_ack));
    chk("res_valid", 32'(res_valid), 32'(x_rv));
    chk("res_ch", 32'(res_ch), 32'(x_rch));
    chk("res_ns", 32'(res_ns), 32'(x_rns));
    chk("res_y", 32'(res_y), 32'(x_ry));
    chk("ctx_state", 32'(ctx_state), 32'(xs));
    chk("ev_ps", 32'(ev_ps), 32'(x_eps));
    chk("ev_a", 32'(ev_a), 32'(x_ea));
    chk("ev_b", 32'(ev_b), 32'(x_eb));
  endtask

  task automatic run_cycle();
    prev_ack = ack;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_all();
    chk("no_consec_ack", 32'(ack & prev_ack), 32'd0);
  endtask

  // Let pending requests complete legally, then flush the pipeline
  task automatic drain();
    ctx_clr = '0;
    for (int k = 0; k < 4 * NCH && req != '0; k++) begin
      req = req & ~x_ack;
      run_cycle();
    end
    req = req & ~x_ack;
    run_cycle();
    run_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [1:0] seq_a [3];
    logic [1:0] seq_b [3];
    m_reset();
    prev_ack = '0;
    repeat (2) @(negedge clk);
    check_all();
    chk("reset_ctx", 32'(ctx_state), 32'd0);
    rst_n = 1'b1;

    // Channel 0: a=1, then b=1, then anything -> 01, 10, 00 (third y=1)
    seq_a[0] = 2'b01; seq_a[1] = 2'b00; seq_a[2] = 2'b01;
    seq_b[0] = 2'b00; seq_b[1] = 2'b01; seq_b[2] = 2'b01;
    for (int s = 0; s < 3; s++) begin
      req[0] = 1'b1; a_in[0] = seq_a[s][0]; b_in[0] = seq_b[s][0];
      run_cycle();
      chk("t2_ack0", 32'(ack), 32'd1);
      req[0] = 1'b0;
      run_cycle();
      chk("t2_res_ns", 32'(res_ns), (s == 0) ? 32'd1 : (s == 1) ? 32'd2 : 32'd0);
      chk("t2_res_y", 32'(res_y), (s == 2) ? 32'd1 : 32'd0);
    end

    // All channels requesting continuously with a=0
    a_in = '0; b_in = '0;
    for (int k = 0; k < 12; k++) begin
      req = '1;
      run_cycle();
    end
    drain();

    // Channel 2 to state 01, then clear on the same edge as a b=1 writeback
    req[2] = 1'b1; a_in[2] = 1'b1; b_in[2] = 1'b0;
    run_cycle();
    req[2] = 1'b0;
    run_cycle();
    chk("t4_ctx2_01", 32'(ctx_state[5:4]), 32'd1);
    req[2] = 1'b1; a_in[2] = 1'b0; b_in[2] = 1'b1;
    run_cycle();
    ctx_clr[2] = 1'b1;
    run_cycle();
    chk("t4_res_ns", 32'(res_ns), 32'd2);
    chk("t4_ctx2_clr", 32'(ctx_state[5:4]), 32'd0);
    run_cycle();
    chk("t4_no_grant", 32'(ack), 32'd0);
    ctx_clr[2] = 1'b0;
    run_cycle();
    chk("t4_grant_after", 32'(ack), 32'd4);
    req[2] = 1'b0;
    run_cycle();

    // Only channel 3 requesting: alternating grants
    for (int k = 0; k < 8; k++) begin
      req = 4'b1000;
      run_cycle();
    end
    drain();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      req = req & ~x_ack;
      ctx_clr = '0;
      for (int i = 0; i < NCH; i++) begin
        if (!req[i] && ($urandom_range(1, 0) == 1)) begin
          req[i]  = 1'b1;
          a_in[i] = 1'($urandom_range(1, 0));
          b_in[i] = 1'($urandom_range(1, 0));
        end
        if ($urandom_range(7, 0) == 0) ctx_clr[i] = 1'b1;
      end
      run_cycle();
    end
    drain();

    // Asynchronous reset while a grant sits in stage E
    req[1] = 1'b1; a_in[1] = 1'b1;
    run_cycle();
    chk("t5_ack_before", 32'(ack), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_ack", 32'(ack), 32'd0);
    chk("t5_res_valid", 32'(res_valid), 32'd0);
    chk("t5_ctx", 32'(ctx_state), 32'd0);
    chk("t5_ev_ps", 32'(ev_ps), 32'd0);
    chk("t5_ev_a", 32'(ev_a), 32'd0);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    run_cycle();
    chk("t5_no_res", 32'(res_valid), 32'd0);
    run_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
